// File: rtl/rc4_crack_pkg.sv
// Shared widths, index type and sequencer state encoding for the RC4 key-search blocks.
package rc4_crack_pkg;

    localparam int unsigned KEY_W    = 24;
    localparam int unsigned SEARCH_W = 22;

    typedef logic [SEARCH_W-1:0] search_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RES,
        FOUND,
        EXHAUSTED,
        STOPPED
    } seq_state_t;

endpackage

// File: rtl/key_range_sequencer.sv
// Per-core candidate-key generator: walks BEGIN_SEARCH..END_SEARCH, offers each key to the
// RC4 core over valid/ready, waits for the verdict and stops on match, exhaustion or stop.
// Optional build macro KEY_SEQ_ATTEMPTS_EN adds a saturating completed-candidate counter;
// without it the attempts port is tied to zero.
// reset_n is active-high despite its name (driven from ~KEY[3]).
module key_range_sequencer
    import rc4_crack_pkg::*;
#(
    parameter search_idx_t BEGIN_SEARCH = 22'h000000,
    parameter search_idx_t END_SEARCH   = 22'h0FFFFF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                stop,
    output logic                cand_valid,
    input  logic                cand_ready,
    output logic [KEY_W-1:0]    cand_key,
    input  logic                res_valid,
    input  logic                res_match,
    output logic                busy,
    output logic                found,
    output logic [KEY_W-1:0]    found_key,
    output logic                exhausted,
    output logic [SEARCH_W-1:0] attempts
);

    seq_state_t        state_q, state_d;
    search_idx_t       idx_q, idx_d;
    logic              found_q, found_d;
    logic [KEY_W-1:0]  found_key_q, found_key_d;
    logic              exhausted_q, exhausted_d;
    logic              cand_valid_q;
    logic [KEY_W-1:0]  cand_key_q;
    logic              busy_q;

    // Next-state, index and sticky-flag logic; a match beats a simultaneous stop.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        found_d     = found_q;
        found_key_d = found_key_q;
        exhausted_d = exhausted_q;
        case (state_q)
            ISSUE: begin
                if (stop) begin
                    state_d = STOPPED;
                end else if (cand_ready) begin
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (res_valid && res_match) begin
                    found_d     = 1'b1;
                    found_key_d = cand_key_q;
                    state_d     = FOUND;
                end else if (stop) begin
                    state_d = STOPPED;
                end else if (res_valid) begin
                    // Compare before incrementing so an all-ones END_SEARCH never wraps.
                    if (idx_q == END_SEARCH) begin
                        exhausted_d = 1'b1;
                        state_d     = EXHAUSTED;
                    end else begin
                        idx_d   = idx_q + search_idx_t'(1);
                        state_d = ISSUE;
                    end
                end
            end
            default: begin
                // IDLE and the terminal states only react to start.
                if (start) begin
                    found_d     = 1'b0;
                    found_key_d = '0;
                    exhausted_d = 1'b0;
                    if (BEGIN_SEARCH <= END_SEARCH) begin
                        idx_d   = BEGIN_SEARCH;
                        state_d = ISSUE;
                    end else begin
                        state_d = EXHAUSTED;
                    end
                end
            end
        endcase
    end

    // State, index and registered outputs derived from the next state.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            found_q      <= 1'b0;
            found_key_q  <= '0;
            exhausted_q  <= 1'b0;
            cand_valid_q <= 1'b0;
            cand_key_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            found_q      <= found_d;
            found_key_q  <= found_key_d;
            exhausted_q  <= exhausted_d;
            cand_valid_q <= (state_d == ISSUE);
            cand_key_q   <= KEY_W'(idx_d);
            busy_q       <= (state_d == ISSUE) || (state_d == WAIT_RES);
        end
    end

`ifdef KEY_SEQ_ATTEMPTS_EN
    search_idx_t attempts_q, attempts_d;

    // Count verdicts taken in WAIT_RES, saturating; a restart clears the count.
    always_comb begin
        attempts_d = attempts_q;
        if (start && !busy_q) begin
            attempts_d = '0;
        end else if ((state_q == WAIT_RES) && res_valid && (res_match || !stop)
                     && (attempts_q != '1)) begin
            attempts_d = attempts_q + search_idx_t'(1);
        end
    end

    // Attempts counter register.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            attempts_q <= '0;
        end else begin
            attempts_q <= attempts_d;
        end
    end

    assign attempts = attempts_q;
`else
    assign attempts = '0;
`endif

    assign cand_valid = cand_valid_q;
    assign cand_key   = cand_key_q;
    assign busy       = busy_q;
    assign found      = found_q;
    assign found_key  = found_key_q;
    assign exhausted  = exhausted_q;

endmodule
